// File: rtl/axi_led_regs.sv
// axi_led_regs: AXI3 slave with LED, blink mask, blink divider and ID regs.
// Ports: i_clk, i_rst (async, active-low), AXI3 AW/W/B/AR/R, o_led[7:0].
module axi_led_regs #(
  parameter int          ADDR_W   = 32,
  parameter int          ID_W     = 12,
  parameter logic [31:0] BLOCK_ID = 32'h4C454438
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ID_W-1:0]   i_axi_awid,
  input  logic [ADDR_W-1:0] i_axi_awaddr,
  input  logic [3:0]        i_axi_awlen,
  input  logic [1:0]        i_axi_awburst,
  input  logic              i_axi_awvalid,
  output logic              o_axi_awready,
  input  logic [31:0]       i_axi_wdata,
  input  logic [3:0]        i_axi_wstrb,
  input  logic              i_axi_wlast,
  input  logic              i_axi_wvalid,
  output logic              o_axi_wready,
  output logic [ID_W-1:0]   o_axi_bid,
  output logic [1:0]        o_axi_bresp,
  output logic              o_axi_bvalid,
  input  logic              i_axi_bready,
  input  logic [ID_W-1:0]   i_axi_arid,
  input  logic [ADDR_W-1:0] i_axi_araddr,
  input  logic [3:0]        i_axi_arlen,
  input  logic [1:0]        i_axi_arburst,
  input  logic              i_axi_arvalid,
  output logic              o_axi_arready,
  output logic [ID_W-1:0]   o_axi_rid,
  output logic [31:0]       o_axi_rdata,
  output logic [1:0]        o_axi_rresp,
  output logic              o_axi_rlast,
  output logic              o_axi_rvalid,
  input  logic              i_axi_rready,
  output logic [7:0]        o_led
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  // Holds the address channels off for the first cycle out of reset.
  logic rdy_q;

  wstate_e ws_q, ws_d;
  logic [ID_W-1:0]   bid_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [3:0]        wlen_q, wcnt_q;
  logic              wfix_q, werr_q;

  rstate_e rs_q, rs_d;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [3:0]        rlen_q, rcnt_q;
  logic              rfix_q, rwrap_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              rlast_q;

  logic [7:0]  led_q, mask_q, oled_q;
  logic [31:0] div_q, cnt_q;
  logic        phase_q;

  logic aw_hs, w_hs, w_last, w_inr;
  logic we_led, we_mask, we_div;
  logic ar_hs, r_hs;
  logic [ADDR_W-1:0] ld_addr, ld_next;
  logic              ld_inr, ld_wrap, ld_fix;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic              unused_ok;

  assign o_axi_awready = rdy_q && (ws_q == W_IDLE);
  assign o_axi_wready  = (ws_q == W_DATA);
  assign o_axi_bvalid  = (ws_q == W_RESP);
  assign o_axi_bid     = bid_q;
  assign o_axi_bresp   = {werr_q, 1'b0};

  assign o_axi_arready = rdy_q && (rs_q == R_IDLE);
  assign o_axi_rvalid  = (rs_q == R_DATA);
  assign o_axi_rid     = rid_q;
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;
  assign o_axi_rlast   = rlast_q;
  assign o_led         = oled_q;

  assign aw_hs  = i_axi_awvalid && o_axi_awready;
  assign w_hs   = i_axi_wvalid && o_axi_wready;
  assign w_last = (wcnt_q == wlen_q);
  assign w_inr  = ~|waddr_q[ADDR_W-1:4];
  assign we_led  = w_hs && w_inr && (waddr_q[3:2] == 2'd0);
  assign we_mask = w_hs && w_inr && (waddr_q[3:2] == 2'd1);
  assign we_div  = w_hs && w_inr && (waddr_q[3:2] == 2'd2);

  assign ar_hs = i_axi_arvalid && o_axi_arready;
  assign r_hs  = o_axi_rvalid && i_axi_rready;

  assign unused_ok = ^{waddr_q[1:0], ld_addr[1:0]};

  always_comb begin
    ws_d = ws_q;
    unique case (ws_q)
      W_IDLE: if (aw_hs) ws_d = W_DATA;
      W_DATA: if (w_hs && w_last) ws_d = W_RESP;
      W_RESP: if (i_axi_bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  always_comb begin
    rs_d = rs_q;
    unique case (rs_q)
      R_IDLE: if (ar_hs) rs_d = R_DATA;
      R_DATA: if (r_hs && rlast_q) rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
  end

  // Beat 0 loads straight from the AR channel; later beats from raddr_q.
  always_comb begin
    ld_addr = (rs_q == R_IDLE) ? i_axi_araddr : raddr_q;
    ld_wrap = (rs_q == R_IDLE) ? (i_axi_arburst == 2'b10) : rwrap_q;
    ld_fix  = (rs_q == R_IDLE) ? (i_axi_arburst == 2'b00) : rfix_q;
    ld_next = ld_fix ? ld_addr : ld_addr + ADDR_W'(4);
    ld_inr  = ~|ld_addr[ADDR_W-1:4];
    rd_data = '0;
    if (ld_inr) begin
      unique case (ld_addr[3:2])
        2'd0: rd_data = {24'd0, led_q};
        2'd1: rd_data = {24'd0, mask_q};
        2'd2: rd_data = div_q;
        2'd3: rd_data = BLOCK_ID;
        default: rd_data = '0;
      endcase
    end
    rd_resp = (!ld_inr || ld_wrap) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rdy_q   <= 1'b0;
      ws_q    <= W_IDLE;
      rs_q    <= R_IDLE;
      bid_q   <= '0;
      waddr_q <= '0;
      wlen_q  <= '0;
      wcnt_q  <= '0;
      wfix_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      ws_q  <= ws_d;
      rs_q  <= rs_d;
      if (aw_hs) begin
        bid_q   <= i_axi_awid;
        waddr_q <= i_axi_awaddr;
        wlen_q  <= i_axi_awlen;
        wcnt_q  <= '0;
        wfix_q  <= (i_axi_awburst == 2'b00);
        werr_q  <= (i_axi_awburst == 2'b10);
      end else if (w_hs) begin
        wcnt_q <= wcnt_q + 4'd1;
        if (!wfix_q) waddr_q <= waddr_q + ADDR_W'(4);
        if (!w_inr || (i_axi_wlast != w_last)) werr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rid_q   <= '0;
      raddr_q <= '0;
      rlen_q  <= '0;
      rcnt_q  <= '0;
      rfix_q  <= 1'b0;
      rwrap_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
    end else if (ar_hs) begin
      rid_q   <= i_axi_arid;
      rlen_q  <= i_axi_arlen;
      rcnt_q  <= '0;
      rfix_q  <= ld_fix;
      rwrap_q <= ld_wrap;
      raddr_q <= ld_next;
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
      rlast_q <= (i_axi_arlen == 4'd0);
    end else if (r_hs && !rlast_q) begin
      rcnt_q  <= rcnt_q + 4'd1;
      raddr_q <= ld_next;
      rdata_q <= rd_data;
      rresp_q <= rd_resp;
      rlast_q <= (rcnt_q + 4'd1 == rlen_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      led_q   <= '0;
      mask_q  <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      oled_q  <= '0;
    end else begin
      if (we_led && i_axi_wstrb[0]) led_q <= i_axi_wdata[7:0];
      if (we_mask && i_axi_wstrb[0]) mask_q <= i_axi_wdata[7:0];
      if (we_div) begin
        for (int b = 0; b < 4; b++) begin
          if (i_axi_wstrb[b]) div_q[8*b +: 8] <= i_axi_wdata[8*b +: 8];
        end
      end
      if (we_div || (div_q == 32'd0)) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (cnt_q == div_q - 32'd1) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
      oled_q <= led_q ^ (mask_q & {8{phase_q}});
    end
  end

endmodule

// File: tb/tb_axi_led_regs.sv
// tb_axi_led_regs: directed + random AXI3 traffic against a register model.
// Checks handshakes, responses, read data, and the LED/blink output.
module tb_axi_led_regs;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [11:0] i_axi_awid = '0;
  logic [31:0] i_axi_awaddr = '0;
  logic [3:0]  i_axi_awlen = '0;
  logic [1:0]  i_axi_awburst = '0;
  logic        i_axi_awvalid = 1'b0;
  logic        o_axi_awready;
  logic [31:0] i_axi_wdata = '0;
  logic [3:0]  i_axi_wstrb = '0;
  logic        i_axi_wlast = 1'b0;
  logic        i_axi_wvalid = 1'b0;
  logic        o_axi_wready;
  logic [11:0] o_axi_bid;
  logic [1:0]  o_axi_bresp;
  logic        o_axi_bvalid;
  logic        i_axi_bready = 1'b0;
  logic [11:0] i_axi_arid = '0;
  logic [31:0] i_axi_araddr = '0;
  logic [3:0]  i_axi_arlen = '0;
  logic [1:0]  i_axi_arburst = '0;
  logic        i_axi_arvalid = 1'b0;
  logic        o_axi_arready;
  logic [11:0] o_axi_rid;
  logic [31:0] o_axi_rdata;
  logic [1:0]  o_axi_rresp;
  logic        o_axi_rlast;
  logic        o_axi_rvalid;
  logic        i_axi_rready = 1'b0;
  logic [7:0]  o_led;

  axi_led_regs dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_axi_awid(i_axi_awid), .i_axi_awaddr(i_axi_awaddr),
    .i_axi_awlen(i_axi_awlen), .i_axi_awburst(i_axi_awburst),
    .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready),
    .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb),
    .i_axi_wlast(i_axi_wlast), .i_axi_wvalid(i_axi_wvalid),
    .o_axi_wready(o_axi_wready), .o_axi_bid(o_axi_bid),
    .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid),
    .i_axi_bready(i_axi_bready), .i_axi_arid(i_axi_arid),
    .i_axi_araddr(i_axi_araddr), .i_axi_arlen(i_axi_arlen),
    .i_axi_arburst(i_axi_arburst), .i_axi_arvalid(i_axi_arvalid),
    .o_axi_arready(o_axi_arready), .o_axi_rid(o_axi_rid),
    .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp),
    .o_axi_rlast(o_axi_rlast), .o_axi_rvalid(o_axi_rvalid),
    .i_axi_rready(i_axi_rready), .o_led(o_led)
  );

  always #5 i_clk = ~i_clk;

  // Edge index: read at a negedge it names the posedge just passed.
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  logic [7:0]  m_led = '0;
  logic [7:0]  m_mask = '0;
  logic [31:0] m_div = '0;
  int          t0 = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a[31:4] != 28'd0) return 32'd0;
    case (a[3:2])
      2'd0: return {24'd0, m_led};
      2'd1: return {24'd0, m_mask};
      2'd2: return m_div;
      default: return 32'h4C454438;
    endcase
  endfunction

  function automatic logic [1:0] mresp(input logic [31:0] a);
    return (a[31:4] != 28'd0) ? 2'b10 : 2'b00;
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int t);
    if (a[31:4] == 28'd0) begin
      case (a[3:2])
        2'd0: if (s[0]) m_led = d[7:0];
        2'd1: if (s[0]) m_mask = d[7:0];
        2'd2: begin
          for (int b = 0; b < 4; b++)
            if (s[b]) m_div[8*b +: 8] = d[8*b +: 8];
          t0 = t;
        end
        default: ;
      endcase
    end
  endtask

  // Phase after edge u is floor((u-t0)/div) mod 2; o_led after
  // edge t shows the phase after edge t-1.
  function automatic logic [7:0] mled(input int t);
    logic   ph;
    longint d;
    ph = 1'b0;
    if (m_div != 32'd0) begin
      d = longint'(t - 1 - t0) / longint'({32'd0, m_div});
      ph = d[0];
    end
    return m_led ^ (m_mask & {8{ph}});
  endfunction

  function automatic logic any_out();
    return |{o_axi_awready, o_axi_wready, o_axi_bid, o_axi_bresp,
             o_axi_bvalid, o_axi_arready, o_axi_rid, o_axi_rdata,
             o_axi_rresp, o_axi_rlast, o_axi_rvalid, o_led};
  endfunction

  task automatic wr_burst(input logic [31:0] addr, input logic [11:0] id,
                          input logic [3:0] len, input logic [1:0] burst,
                          input int early, input int gap);
    int n;
    logic err;
    logic [31:0] a;
    i_axi_awid = id; i_axi_awaddr = addr;
    i_axi_awlen = len; i_axi_awburst = burst;
    i_axi_awvalid = 1'b1;
    n = 0;
    while (!o_axi_awready && n < 64) begin @(negedge i_clk); n++; end
    chk("aw_wait", n < 64, 1);
    @(negedge i_clk);
    i_axi_awvalid = 1'b0;
    chk("w_lat", o_axi_wready, 1);
    err = (burst == 2'b10);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      i_axi_wvalid = 1'b1; i_axi_wdata = wd[i]; i_axi_wstrb = ws[i];
      i_axi_wlast = (i == int'(len)) || (i == early);
      n = 0;
      while (!o_axi_wready && n < 64) begin @(negedge i_clk); n++; end
      chk("w_wait", n < 64, 1);
      @(negedge i_clk);
      i_axi_wvalid = 1'b0;
      if (a[31:4] != 28'd0) err = 1'b1;
      else mwrite(a, wd[i], ws[i], cyc);
      if (i == early && early != int'(len)) err = 1'b1;
      if (burst != 2'b00) a = a + 32'd4;
      if (i < int'(len)) begin
        chk("b_early", o_axi_bvalid, 0);
        repeat (gap) @(negedge i_clk);
      end
    end
    chk("b_lat", o_axi_bvalid, 1);
    i_axi_wlast = 1'b0;
    i_axi_bready = 1'b1;
    n = 0;
    while (!o_axi_bvalid && n < 64) begin @(negedge i_clk); n++; end
    chk("bid", o_axi_bid, id);
    chk("bresp", o_axi_bresp, err ? 2'b10 : 2'b00);
    @(negedge i_clk);
    i_axi_bready = 1'b0;
    chk("led_w", o_led, mled(cyc));
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [11:0] id,
                          input logic [3:0] len, input logic [1:0] burst,
                          input int sb, input int sn);
    int n;
    logic [31:0] a;
    i_axi_arid = id; i_axi_araddr = addr;
    i_axi_arlen = len; i_axi_arburst = burst;
    i_axi_arvalid = 1'b1;
    n = 0;
    while (!o_axi_arready && n < 64) begin @(negedge i_clk); n++; end
    chk("ar_wait", n < 64, 1);
    @(negedge i_clk);
    i_axi_arvalid = 1'b0;
    chk("r_lat", o_axi_rvalid, 1);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == sb) begin
        i_axi_rready = 1'b0;
        repeat (sn) begin
          @(negedge i_clk);
          chk("r_hold", o_axi_rdata, mdata(a));
        end
      end
      i_axi_rready = 1'b1;
      n = 0;
      while (!o_axi_rvalid && n < 64) begin @(negedge i_clk); n++; end
      chk("rdata", o_axi_rdata, mdata(a));
      chk("rresp", o_axi_rresp, mresp(a));
      chk("rlast", o_axi_rlast, i == int'(len));
      chk("rid", o_axi_rid, id);
      @(negedge i_clk);
      if (i < int'(len)) chk("r_nobub", o_axi_rvalid, 1);
      else begin
        chk("r_end", o_axi_rvalid, 0);
        chk("ar_back", o_axi_arready, 1);
      end
      if (burst != 2'b00) a = a + 32'd4;
    end
    i_axi_rready = 1'b0;
    chk("led_r", o_led, mled(cyc));
  endtask

  initial begin
    int n;
    logic [31:0] ra;
    logic [3:0]  rl;

    repeat (5) begin
      @(negedge i_clk);
      chk("rst_out", any_out(), 0);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("awready_up", o_axi_awready, 1);
    chk("arready_up", o_axi_arready, 1);
    chk("led_rst", o_led, 8'h00);

    wd[0] = 32'hA5; ws[0] = 4'hF;
    wr_burst(32'h0, 12'h123, 4'd0, 2'b01, -1, 0);
    chk("led_a5", o_led, 8'hA5);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    wr_burst(32'h8, 12'h001, 4'd0, 2'b01, -1, 0);
    wd[0] = 32'h0000FF00; ws[0] = 4'h2;
    wr_burst(32'h8, 12'h002, 4'd0, 2'b01, -1, 0);
    wd[0] = 32'h5A; ws[0] = 4'h1;
    wr_burst(32'h4, 12'h003, 4'd0, 2'b01, -1, 0);
    rd_burst(32'h0, 12'h0AB, 4'd3, 2'b01, 1, 3);

    wd[0] = 32'hF0; wd[1] = 32'h0F; wd[2] = 32'd4;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    wr_burst(32'h0, 12'h004, 4'd2, 2'b01, -1, 1);
    repeat (16) begin
      @(negedge i_clk);
      chk("blink", o_led, mled(cyc));
    end
    wd[0] = 32'd0; ws[0] = 4'hF;
    wr_burst(32'h8, 12'h005, 4'd0, 2'b01, -1, 0);
    repeat (8) begin
      @(negedge i_clk);
      chk("blink_off", o_led, 8'hF0);
    end

    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    wr_burst(32'h10, 12'h006, 4'd0, 2'b01, -1, 0);
    rd_burst(32'h0, 12'h00C, 4'd3, 2'b01, -1, 0);
    wd[0] = 32'h3C; wd[1] = 32'h00; wd[2] = 32'h0; wd[3] = 32'h77;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    wr_burst(32'h0, 12'h007, 4'd3, 2'b01, 1, 0);
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33;
    wr_burst(32'h0, 12'h008, 4'd2, 2'b00, -1, 0);
    chk("fixed_led", o_led, 8'h33);
    rd_burst(32'h0, 12'h009, 4'd3, 2'b01, -1, 0);

    i_axi_arid = 12'h055; i_axi_araddr = 32'h0;
    i_axi_arlen = 4'd7; i_axi_arburst = 2'b01;
    i_axi_arvalid = 1'b1;
    n = 0;
    while (!o_axi_arready && n < 64) begin @(negedge i_clk); n++; end
    chk("ar_wait8", n < 64, 1);
    @(negedge i_clk);
    i_axi_arvalid = 1'b0;
    i_axi_rready = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("rb2_valid", o_axi_rvalid, 1);
    chk("rb2_data", o_axi_rdata, mdata(32'h8));
    i_rst = 1'b0;
    #1;
    chk("rst_rvalid", o_axi_rvalid, 0);
    chk("rst_mid", any_out(), 0);
    m_led = '0; m_mask = '0; m_div = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      chk("no_r_after", o_axi_rvalid, 0);
    end
    i_axi_rready = 1'b0;
    rd_burst(32'h4, 12'h066, 4'd1, 2'b01, -1, 0);

    for (int k = 0; k < 30; k++) begin
      ra = 32'($urandom_range(0, 5)) << 2;
      if ($urandom_range(0, 7) == 0) ra = ra | 32'h80000000;
      rl = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j <= int'(rl); j++) begin
          wd[j] = ($urandom_range(0, 3) == 0) ? $urandom
                                              : 32'($urandom_range(0, 9));
          ws[j] = 4'($urandom_range(0, 15));
        end
        wr_burst(ra, 12'($urandom), rl, 2'($urandom_range(0, 2)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rl))
                                             : -1,
                 int'($urandom_range(0, 2)));
      end else begin
        rd_burst(ra, 12'($urandom), rl, 2'($urandom_range(0, 1)),
                 int'($urandom_range(0, rl)), int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
